button_keypad_encoder: RTL and testbench
========================================

Name: button_keypad_encoder

Overview:
- Front-end for the 12 push-button switches of the roulette board.
- Synchronises and debounces the raw buttons and rejects multi-key presses.
- Emits exactly one single-cycle key event per physical press as key_valid / key_value.
- Sits directly upstream of the game FSM and the user-number capture logic, which consume key_valid / key_value.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable cycles required for press and for release (20 ms at 50 MHz); must be >= 2.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_HIGH, 1, 1 = button reads 1 when pressed; 0 = inputs inverted after synchronisation.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock; reset is synchronous and active-low
- key01..key12  in  1 each  raw asynchronous button levels; keyNN maps to code NN
- key_valid  out  1  single-cycle pulse, one per accepted press
- key_value  out  4  code of the accepted key (1..12); held until the next accepted press
- key_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Input conditioning
  - Each key passes a 2-FF synchroniser, then an optional inversion (ACTIVE_HIGH=0).
  - The result is the 12-bit vector kv, bit i-1 = keyNN with NN=i.
  - Synchroniser latency is 2 cycles; all FSM decisions use kv.
- Reset (rst==0 at posedge)
  - Synchroniser flops = 0; state = IDLE; counter = 0; cand = 0.
  - Outputs: key_valid=0, key_value=4'd0, key_busy=0.
  - Reset asserted mid-debounce or while held aborts silently: no pulse is emitted.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE:
    - kv has exactly one bit set → latch cand = that code (1..12), clear counter, go to PRESS_DB.
    - kv == 0 or two or more bits set → stay in IDLE.
  - PRESS_DB:
    - If kv != one-hot(cand) (bounce, release, or a second key) → return to IDLE, counter cleared, no event.
    - Otherwise counter increments.
    - When counter reaches DEBOUNCE_CYCLES-1 with kv still matching: next cycle key_valid=1 and key_value=cand (both registered in the same cycle); go to HELD.
  - HELD:
    - key_valid = 0.
    - Remain while kv != 0, with no repeat events; extra keys pressed while held are ignored.
    - kv == 0 → clear counter, go to RELEASE_DB.
  - RELEASE_DB:
    - kv != 0 → back to HELD (bounce on release), counter cleared.
    - Counter reaches DEBOUNCE_CYCLES-1 with kv == 0 → go to IDLE.
- Latency: key_valid asserts exactly DEBOUNCE_CYCLES + 3 cycles after a clean edge appears on the raw pin (2 sync + 1 IDLE + DEBOUNCE_CYCLES, with the output registered).
- key_valid
  - Never high for two consecutive cycles.
  - At most one pulse between two IDLE visits.
- Counter saturates logic: it is compared with ==, never wraps inside a state, and is cleared on every state entry.
- key_busy = (state != IDLE); registered, so it follows the state register.
- Simultaneous events
  - Two keys rising in the same cycle while in IDLE → no candidate.
  - One key already in PRESS_DB plus a second key arriving → abort to IDLE; a new press is then only accepted once a single key remains.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Reset: hold rst=0 for 3 cycles with key05=1 → key_valid=0, key_value=0, key_busy=0 throughout; after release, a press of key05 (still held) is accepted once, key_value=5.
- Clean press: key07 high for 20 cycles then low → exactly one key_valid pulse at cycle 7 after the edge, key_value=7; no further pulses; key_busy returns to 0 four or more cycles after release.
- Bounce: key03 toggles 1,0,1,0 at 1-cycle spacing, then stays 1 → no pulse during bouncing; a single pulse with value 3 arrives after the stable period.
- Multi-key: key01 and key12 asserted in the same cycle for 20 cycles → no pulse; release key01 → a pulse with value 12 follows after the debounce period.
- Hold and second key: hold key08, get pulse value 8; press key02 while holding key08; release both → no second pulse; a subsequent key02-only press yields value 2.
- Release bounce: after accepting key12, release glitches 0,1,0 → FSM returns to HELD with no extra pulse; after a clean release it reaches IDLE, and the next press of key12 yields one pulse with value 12.

Source files
------------

// File: rtl/button_keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : button_keypad_encoder
//  Purpose  : Front-end for the 12 roulette-board push buttons. Synchronises
//             and debounces the raw levels, rejects multi-key presses and
//             emits one single-cycle key event per accepted physical press.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock (50 MHz)
//    rst        in   synchronous, active-low reset
//    key01..12  in   raw asynchronous button levels; keyNN maps to code NN
//    key_valid  out  single-cycle pulse, one per accepted press
//    key_value  out  code (1..12) of the last accepted key, held between presses
//    key_busy   out  high whenever the debounce FSM is not idle
// ============================================================================
module button_keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key01,
  input  logic       key02,
  input  logic       key03,
  input  logic       key04,
  input  logic       key05,
  input  logic       key06,
  input  logic       key07,
  input  logic       key08,
  input  logic       key09,
  input  logic       key10,
  input  logic       key11,
  input  logic       key12,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic       key_busy
);

  localparam logic [1:0] C_ST_IDLE       = 2'd0;
  localparam logic [1:0] C_ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] C_ST_HELD       = 2'd2;
  localparam logic [1:0] C_ST_RELEASE_DB = 2'd3;

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Input conditioning: 2-FF synchroniser, then optional polarity inversion
  // --------------------------------------------------------------------------
  logic [11:0] w_raw;
  logic [11:0] sync1_q;
  logic [11:0] sync2_q;
  logic [11:0] w_kv;

  assign w_raw = {key12, key11, key10, key09, key08, key07,
                  key06, key05, key04, key03, key02, key01};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= w_raw;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (ACTIVE_HIGH) begin : g_active_high
      assign w_kv = sync2_q;
    end else begin : g_active_low
      assign w_kv = ~sync2_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Key classification: number of pressed keys and code of the pressed key.
  // w_code is only meaningful when exactly one key is down.
  // --------------------------------------------------------------------------
  logic [3:0] w_ones;
  logic [3:0] w_code;
  logic       w_single;
  logic       w_none;

  always_comb begin
    w_ones = 4'd0;
    w_code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_kv[i]) begin
        w_ones = w_ones + 4'd1;
        w_code = 4'(i + 1);
      end
    end
  end

  assign w_single = (w_ones == 4'd1);
  assign w_none   = (w_kv == 12'd0);

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       cand_q,  cand_d;
  logic             valid_q, valid_d;
  logic [3:0]       value_q, value_d;
  logic             busy_q,  busy_d;
  logic             w_match;

  // Only the candidate key, alone, keeps the press debounce alive.
  assign w_match = w_single && (w_code == cand_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    valid_d = 1'b0;
    value_d = value_q;

    case (state_q)
      C_ST_IDLE: begin
        if (w_single) begin
          cand_d  = w_code;
          cnt_d   = '0;
          state_d = C_ST_PRESS_DB;
        end
      end

      C_ST_PRESS_DB: begin
        if (!w_match) begin
          cnt_d   = '0;
          state_d = C_ST_IDLE;
        end else if (cnt_q == C_CNT_MAX) begin
          valid_d = 1'b1;
          value_d = cand_q;
          cnt_d   = '0;
          state_d = C_ST_HELD;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      // Any key activity keeps us here; extra keys never produce events.
      C_ST_HELD: begin
        if (w_none) begin
          cnt_d   = '0;
          state_d = C_ST_RELEASE_DB;
        end
      end

      C_ST_RELEASE_DB: begin
        if (!w_none) begin
          cnt_d   = '0;
          state_d = C_ST_HELD;
        end else if (cnt_q == C_CNT_MAX) begin
          cnt_d   = '0;
          state_d = C_ST_IDLE;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = C_ST_IDLE;
      end
    endcase

    // Registered from the next state so it tracks the state register exactly.
    busy_d = (state_d != C_ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= C_ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
      valid_q <= 1'b0;
      value_q <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      value_q <= value_d;
      busy_q  <= busy_d;
    end
  end

  assign key_valid = valid_q;
  assign key_value = value_q;
  assign key_busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_button_keypad_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_keypad_encoder
//  Purpose  : Self-checking bench for button_keypad_encoder. A reference model
//             working on the delayed key history predicts each key event and
//             pushes it into a scoreboard; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_keypad_encoder;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] keys;
  logic        key_valid;
  logic [3:0]  key_value;
  logic        key_busy;

  always #5 clk = ~clk;

  button_keypad_encoder #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .ACTIVE_HIGH     (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key01     (keys[0]),
    .key02     (keys[1]),
    .key03     (keys[2]),
    .key04     (keys[3]),
    .key05     (keys[4]),
    .key06     (keys[5]),
    .key07     (keys[6]),
    .key08     (keys[7]),
    .key09     (keys[8]),
    .key10     (keys[9]),
    .key11     (keys[10]),
    .key12     (keys[11]),
    .key_valid (key_valid),
    .key_value (key_value),
    .key_busy  (key_busy)
  );

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_pushed = 0;
  int   n_seen   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int key_code(input logic [11:0] v);
    int c = 0;
    for (int i = 0; i < 12; i++) if (v[i]) c = i + 1;
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model. The FSM sees the raw levels two clocks late. A press is
  // accepted once the same lone key is seen on D+1 consecutive samples while
  // armed; a sample breaking a run is consumed and cannot start a new run.
  // After an accept, D+1 consecutive all-released samples re-arm the model.
  // --------------------------------------------------------------------------
  logic [11:0] h1, h2, kv;
  bit  armed    = 1'b1;
  int  run      = 0;
  int  zrun     = 0;
  int  cand     = 0;
  bit  in_reset = 1'b1;
  bit  exp_busy = 1'b0;
  int  exp_val  = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      h1 = '0; h2 = '0;
      armed = 1'b1; run = 0; zrun = 0; cand = 0;
      exp_busy = 1'b0; exp_val = 0; in_reset = 1'b1;
    end else begin
      in_reset = 1'b0;
      kv = h2;
      if (armed) begin
        if (run == 0) begin
          if ($countones(kv) == 1) begin
            run  = 1;
            cand = key_code(kv);
          end
        end else if ($countones(kv) == 1 && key_code(kv) == cand) begin
          run++;
          if (run == D + 1) begin
            sb.push_back('{code: cand, cyc: cyc});
            n_pushed++;
            exp_val = cand;
            armed = 1'b0; run = 0; zrun = 0;
          end
        end else begin
          run = 0;
        end
      end else begin
        if (kv == 12'd0) begin
          zrun++;
          if (zrun == D + 1) begin
            armed = 1'b1; zrun = 0;
          end
        end else begin
          zrun = 0;
        end
      end
      exp_busy = !armed || (run > 0);
      h2 = h1;
      h1 = keys;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: sampled on the falling edge, away from the active edge.
  // --------------------------------------------------------------------------
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    if (in_reset) begin
      check("reset_valid", int'(key_valid), 0);
      check("reset_value", int'(key_value), 0);
      check("reset_busy",  int'(key_busy),  0);
    end else begin
      bit exp_v;
      exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("key_valid", int'(key_valid), int'(exp_v));
      if (exp_v) begin
        exp_t e;
        e = sb.pop_front();
        check("event_value", int'(key_value), e.code);
      end
      if (key_valid) n_seen++;
      check("key_value_held", int'(key_value), exp_val);
      check("key_busy", int'(key_busy), int'(exp_busy));
      check("no_back_to_back", int'(prev_valid && key_valid), 0);
    end
    prev_valid = key_valid;
  end

  // --------------------------------------------------------------------------
  // Stimulus (changes 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic hold(input logic [11:0] v, input int n);
    keys = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_for(input logic [11:0] v, input int n);
    rst  = 1'b0;
    keys = v;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  localparam logic [11:0] K01 = 12'h001;
  localparam logic [11:0] K02 = 12'h002;
  localparam logic [11:0] K03 = 12'h004;
  localparam logic [11:0] K05 = 12'h010;
  localparam logic [11:0] K06 = 12'h020;
  localparam logic [11:0] K07 = 12'h040;
  localparam logic [11:0] K08 = 12'h080;
  localparam logic [11:0] K12 = 12'h800;

  initial begin
    rst  = 1'b0;
    keys = '0;
    @(posedge clk); #1;

    // Reset held with key05 down, then key05 accepted once.
    reset_for(K05, 3);
    hold(K05, 20);
    hold('0, 20);

    // Clean press.
    hold(K07, 20);
    hold('0, 20);

    // Bounce on press.
    hold(K03, 1); hold('0, 1); hold(K03, 1); hold('0, 1);
    hold(K03, 20);
    hold('0, 20);

    // Two keys together, then one released.
    hold(K01 | K12, 20);
    hold(K12, 20);
    hold('0, 20);

    // Second key while holding.
    hold(K08, 20);
    hold(K08 | K02, 10);
    hold('0, 20);
    hold(K02, 20);
    hold('0, 20);

    // Release bounce.
    hold(K12, 20);
    hold('0, 1); hold(K12, 1); hold('0, 1); hold(K12, 3);
    hold('0, 20);
    hold(K12, 20);
    hold('0, 20);

    // Reset mid-debounce and while held.
    hold(K06, 4);
    reset_for('0, 2);
    hold('0, 5);
    hold(K06, 12);
    reset_for(K06, 2);
    hold(K06, 12);
    hold('0, 20);

    // Randomised presses, bounces and multi-key patterns.
    for (int i = 0; i < 400; i++) begin
      logic [11:0] v;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       v = '0;
      else if (sel < 8)  v = 12'd1 << $urandom_range(0, 11);
      else               v = 12'($urandom);
      hold(v, $urandom_range(1, 9));
    end

    hold('0, 30);
    check("scoreboard_drained", sb.size(), 0);
    check("pulse_count", n_seen, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
